// File: rtl/fpu_result_pipe.sv
// fpu_result_pipe: tracks in-flight FP results from issue to writeback and resolves source operands.
// Optional macro FPU_RESULT_FWD_EN enables forwarding; without it the pipe only flags hazards.
module fpu_result_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 6,
  parameter int NUM_SRC = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clken,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      issue_we,
  input  logic                      issue_ready,
  input  logic [DATA_W-1:0]         issue_data,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_use,
  input  logic [NUM_SRC*DATA_W-1:0] src_rf,
  input  logic [DEPTH-1:0]          inj_en,
  input  logic [DEPTH*DATA_W-1:0]   inj_data,
  output logic [NUM_SRC*DATA_W-1:0] src_op,
  output logic                      hazard,
  output logic                      wb_en,
  output logic [REG_AW-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data
);

  // Issue handshake: an instruction is accepted at a clken=1 edge when issue_valid=1 and
  // hazard=0; in every other case a bubble enters stage 1. There is no back-pressure beyond hazard.

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  we_q, we_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [REG_AW-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic                 issue_accept;
  logic [NUM_SRC-1:0]   src_haz;
  logic [NUM_SRC-1:0]   hit;
`ifdef FPU_RESULT_FWD_EN
  logic [NUM_SRC-1:0]   hit_rdy;
  logic [DATA_W-1:0]    hit_data [NUM_SRC];
`endif
  logic                 unused_inj;

  // The last stage never advances, so its injection slot has no effect.
  assign unused_inj = ^{inj_en[DEPTH-1], inj_data[DEPTH*DATA_W-1 -: DATA_W]};

  assign issue_accept = issue_valid & ~hazard;

  always_comb begin
    valid_d[0] = issue_accept;
    we_d[0]    = issue_accept & issue_we;
    rd_d[0]    = issue_rd;
    ready_d[0] = issue_ready;
    data_d[0]  = issue_data;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      we_d[k]    = we_q[k-1];
      rd_d[k]    = rd_q[k-1];
      ready_d[k] = ready_q[k-1];
      data_d[k]  = data_q[k-1];
      if (inj_en[k-1] && valid_q[k-1]) begin
        ready_d[k] = 1'b1;
        data_d[k]  = inj_data[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      ready_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else if (clken) begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // A not-ready entry reaching the last stage is a unit protocol error and is simply dropped.
  assign wb_en   = clken & valid_q[DEPTH-1] & we_q[DEPTH-1] & ready_q[DEPTH-1];
  assign wb_addr = rd_q[DEPTH-1];
  assign wb_data = data_q[DEPTH-1];

  always_comb begin
    src_op  = src_rf;
    src_haz = '0;
    hit     = '0;
`ifdef FPU_RESULT_FWD_EN
    hit_rdy = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef FPU_RESULT_FWD_EN
      hit_data[i] = '0;
`endif
      // Scan oldest to youngest so the youngest matching producer wins.
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (valid_q[k] && we_q[k] && (rd_q[k] == src_addr[i*REG_AW +: REG_AW])) begin
          hit[i] = 1'b1;
`ifdef FPU_RESULT_FWD_EN
          if ((k < DEPTH-1) && inj_en[k]) begin
            hit_rdy[i]  = 1'b1;
            hit_data[i] = inj_data[k*DATA_W +: DATA_W];
          end else begin
            hit_rdy[i]  = ready_q[k];
            hit_data[i] = data_q[k];
          end
`endif
        end
      end
`ifdef FPU_RESULT_FWD_EN
      if (src_use[i] && hit[i]) begin
        if (hit_rdy[i]) src_op[i*DATA_W +: DATA_W] = hit_data[i];
        else            src_haz[i] = 1'b1;
      end
`else
      src_haz[i] = src_use[i] & hit[i];
`endif
    end
  end

  assign hazard = issue_valid & (|src_haz);

endmodule
